decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered, handshaked RV32I decode stage: successor of the combinational single-cycle decoder.
//  Decodes instr_i into the CTRL_W-bit MI_* control word (riscv_pkg/custom_pkg encodings).
//  Adds valid/ready flow control, a 2-entry skid buffer, flush, illegal-instruction detection
//  and a saturating illegal counter. Sits between fetch and execute of the pipelined core.
// PARAMETERS
//  CTRL_W  18  width of control word (matches MI_* constants)
//  PC_W    32  width of PC carried alongside the instruction
//  CNT_W   16  width of illegal-instruction counter
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       asynchronous active-high reset
//  flush_i        in   1       discard all buffered entries and the beat accepted this cycle
//  valid_i        in   1       upstream beat valid
//  ready_o        out  1       stage can accept a beat
//  instr_i        in   32      instruction word
//  pc_i           in   PC_W    PC of instr_i
//  valid_o        out  1       decoded beat valid
//  ready_i        in   1       downstream accepts beat
//  instr_o        out  32      instruction of head beat
//  pc_o           out  PC_W    PC of head beat
//  ctrl_o         out  CTRL_W  control word of head beat
//  illegal_o      out  1       head beat matched no legal encoding
//  illegal_cnt_o  out  CNT_W   saturating count of accepted illegal beats
// BEHAVIOUR
//  - Reset: valid_o=0, ready_o=1, instr_o/pc_o/ctrl_o=0, illegal_o=0, illegal_cnt_o=0, skid empty.
//  - Decode: casez on {f7,rs2,f3,opcode} as for the RV32I set (LUI..AND); decode is combinational on
//    instr_i, result captured at acceptance. No match -> ctrl=MI_ADDI, illegal=1.
//  - Accept = valid_i & ready_o; emit = valid_o & ready_i. Beats leave in acceptance order.
//  - Storage: output register (head) + skid register. ready_o = !skid_valid (registered, no
//    combinational path from ready_i).
//  - Latency: accept at cycle N with head empty or emitting -> valid_o at N+1.
//  - Head empty or emitting: accepted beat (or skid content, if present, first) loads head.
//  - Head held (valid_o & !ready_i) and accept: beat goes to skid; ready_o=0 next cycle.
//  - Skid full and emit: skid moves to head; ready_o=1 next cycle. Never more than 2 entries.
//  - Simultaneous accept+emit with skid empty: head reloads with new beat, valid_o stays 1.
//  - flush_i: next cycle valid_o=0, skid empty, ready_o=1; beat accepted same cycle is dropped;
//    flush has priority over accept/emit; illegal_cnt_o unaffected by flush.
//  - illegal_cnt_o: +1 on each accept of an illegal beat while flush_i=0; saturates at 2**CNT_W-1.
//  - Payload outputs hold stable while valid_o & !ready_i.
//  - rst_i asserted mid-operation: all state to reset values immediately (async), beats lost.
// CONFIGURATION
//  ZBB_CNT_EN defined: CTZ/CLZ/CPOP encodings decode to MI_CTZ/MI_CLZ/MI_CPOP, illegal=0.
//  ZBB_CNT_EN undefined: those encodings decode as illegal (ctrl=MI_ADDI, illegal=1, counted).
// TESTING
//  1 addi x1,x0,5 (0x00500093) pc=0x100, ready_i=1 -> next cycle valid_o=1, ctrl_o=MI_ADDI,
//    pc_o=0x100, illegal_o=0.
//  2 0x00000000 then 0xFFFFFFFF accepted -> illegal_o=1 each beat, illegal_cnt_o=2.
//  3 ready_i=0, push 0x00500093 then 0x40208033 (sub) -> ready_o=0 after 2nd; ready_i=1 ->
//    emits ADDI then SUB in order, ready_o=1 again.
//  4 two beats buffered, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1,
//    no beat emitted, counter unchanged.
//  5 ctz x1,x2 (0x60111093): with ZBB_CNT_EN -> ctrl_o=MI_CTZ, illegal_o=0;
//    without -> illegal_o=1, counter +1.
//  6 CNT_W=2, five illegal beats -> illegal_cnt_o stays 3; rst_i pulse -> 0, valid_o=0.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module : decode_stage
//  Registered, handshaked RV32I decode stage with a 2-entry skid buffer,
//  flush, illegal detection and a saturating illegal counter.
//  Optional macro ZBB_CNT_EN enables the CLZ/CTZ/CPOP encodings.
//  Rev    : 1.0  initial release
// ============================================================================
module decode_stage #(
  parameter int CTRL_W = 18,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       instr_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       instr_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  // Control word: {rw, mem_rd, mem_wr, branch, jal, jalr, srcb_imm, srca_pc,
  //                wb_sel[1:0], imm_sel[2:0], alu_op[4:0]}
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
  localparam logic [2:0] IS_NONE = 3'd0, IS_I = 3'd1, IS_S = 3'd2,
                         IS_B = 3'd3, IS_U = 3'd4, IS_J = 3'd5;
  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL  = 5'd2,
                         OP_SLT  = 5'd3,  OP_SLTU = 5'd4,  OP_XOR  = 5'd5,
                         OP_SRL  = 5'd6,  OP_SRA  = 5'd7,  OP_OR   = 5'd8,
                         OP_AND  = 5'd9,  OP_PASB = 5'd10, OP_BEQ  = 5'd11,
                         OP_BNE  = 5'd12, OP_BLT  = 5'd13, OP_BGE  = 5'd14,
                         OP_BLTU = 5'd15, OP_BGEU = 5'd16, OP_CTZ  = 5'd17,
                         OP_CLZ  = 5'd18, OP_CPOP = 5'd19;

  localparam logic [7:0] F_IALU = 8'b1000_0010, F_RALU = 8'b1000_0000,
                         F_BR   = 8'b0001_0000;

  localparam logic [17:0] MI_LUI   = {F_IALU,       WB_ALU, IS_U, OP_PASB};
  localparam logic [17:0] MI_AUIPC = {8'b1000_0011, WB_ALU, IS_U, OP_ADD};
  localparam logic [17:0] MI_JAL   = {8'b1000_1000, WB_PC4, IS_J, OP_ADD};
  localparam logic [17:0] MI_JALR  = {8'b1000_0110, WB_PC4, IS_I, OP_ADD};
  localparam logic [17:0] MI_BEQ   = {F_BR, WB_ALU, IS_B, OP_BEQ};
  localparam logic [17:0] MI_BNE   = {F_BR, WB_ALU, IS_B, OP_BNE};
  localparam logic [17:0] MI_BLT   = {F_BR, WB_ALU, IS_B, OP_BLT};
  localparam logic [17:0] MI_BGE   = {F_BR, WB_ALU, IS_B, OP_BGE};
  localparam logic [17:0] MI_BLTU  = {F_BR, WB_ALU, IS_B, OP_BLTU};
  localparam logic [17:0] MI_BGEU  = {F_BR, WB_ALU, IS_B, OP_BGEU};
  // Access size/sign is taken from funct3 of instr_o downstream.
  localparam logic [17:0] MI_LOAD  = {8'b1100_0010, WB_MEM, IS_I, OP_ADD};
  localparam logic [17:0] MI_STORE = {8'b0010_0010, WB_ALU, IS_S, OP_ADD};
  localparam logic [17:0] MI_ADDI  = {F_IALU, WB_ALU, IS_I, OP_ADD};
  localparam logic [17:0] MI_SLTI  = {F_IALU, WB_ALU, IS_I, OP_SLT};
  localparam logic [17:0] MI_SLTIU = {F_IALU, WB_ALU, IS_I, OP_SLTU};
  localparam logic [17:0] MI_XORI  = {F_IALU, WB_ALU, IS_I, OP_XOR};
  localparam logic [17:0] MI_ORI   = {F_IALU, WB_ALU, IS_I, OP_OR};
  localparam logic [17:0] MI_ANDI  = {F_IALU, WB_ALU, IS_I, OP_AND};
  localparam logic [17:0] MI_SLLI  = {F_IALU, WB_ALU, IS_I, OP_SLL};
  localparam logic [17:0] MI_SRLI  = {F_IALU, WB_ALU, IS_I, OP_SRL};
  localparam logic [17:0] MI_SRAI  = {F_IALU, WB_ALU, IS_I, OP_SRA};
  localparam logic [17:0] MI_ADD   = {F_RALU, WB_ALU, IS_NONE, OP_ADD};
  localparam logic [17:0] MI_SUB   = {F_RALU, WB_ALU, IS_NONE, OP_SUB};
  localparam logic [17:0] MI_SLL   = {F_RALU, WB_ALU, IS_NONE, OP_SLL};
  localparam logic [17:0] MI_SLT   = {F_RALU, WB_ALU, IS_NONE, OP_SLT};
  localparam logic [17:0] MI_SLTU  = {F_RALU, WB_ALU, IS_NONE, OP_SLTU};
  localparam logic [17:0] MI_XOR   = {F_RALU, WB_ALU, IS_NONE, OP_XOR};
  localparam logic [17:0] MI_SRL   = {F_RALU, WB_ALU, IS_NONE, OP_SRL};
  localparam logic [17:0] MI_SRA   = {F_RALU, WB_ALU, IS_NONE, OP_SRA};
  localparam logic [17:0] MI_OR    = {F_RALU, WB_ALU, IS_NONE, OP_OR};
  localparam logic [17:0] MI_AND   = {F_RALU, WB_ALU, IS_NONE, OP_AND};
`ifdef ZBB_CNT_EN
  localparam logic [17:0] MI_CTZ   = {F_RALU, WB_ALU, IS_NONE, OP_CTZ};
  localparam logic [17:0] MI_CLZ   = {F_RALU, WB_ALU, IS_NONE, OP_CLZ};
  localparam logic [17:0] MI_CPOP  = {F_RALU, WB_ALU, IS_NONE, OP_CPOP};
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [21:0]       w_key;
  logic [17:0]       w_ctrl;
  logic              w_illegal;
  logic              w_accept;
  logic              w_emit;

  logic              r_head_valid;
  logic [31:0]       r_head_instr;
  logic [PC_W-1:0]   r_head_pc;
  logic [CTRL_W-1:0] r_head_ctrl;
  logic              r_head_ill;
  logic              r_skid_valid;
  logic [31:0]       r_skid_instr;
  logic [PC_W-1:0]   r_skid_pc;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_skid_ill;
  logic [CNT_W-1:0]  r_cnt;

  assign w_key = {instr_i[31:25], instr_i[24:20], instr_i[14:12], instr_i[6:0]};

  always_comb begin
    w_ctrl    = MI_ADDI;
    w_illegal = 1'b0;
    casez (w_key)
      22'b???????_?????_???_0110111: w_ctrl = MI_LUI;
      22'b???????_?????_???_0010111: w_ctrl = MI_AUIPC;
      22'b???????_?????_???_1101111: w_ctrl = MI_JAL;
      22'b???????_?????_000_1100111: w_ctrl = MI_JALR;
      22'b???????_?????_000_1100011: w_ctrl = MI_BEQ;
      22'b???????_?????_001_1100011: w_ctrl = MI_BNE;
      22'b???????_?????_100_1100011: w_ctrl = MI_BLT;
      22'b???????_?????_101_1100011: w_ctrl = MI_BGE;
      22'b???????_?????_110_1100011: w_ctrl = MI_BLTU;
      22'b???????_?????_111_1100011: w_ctrl = MI_BGEU;
      22'b???????_?????_000_0000011,
      22'b???????_?????_001_0000011,
      22'b???????_?????_010_0000011,
      22'b???????_?????_100_0000011,
      22'b???????_?????_101_0000011: w_ctrl = MI_LOAD;
      22'b???????_?????_000_0100011,
      22'b???????_?????_001_0100011,
      22'b???????_?????_010_0100011: w_ctrl = MI_STORE;
      22'b???????_?????_000_0010011: w_ctrl = MI_ADDI;
      22'b???????_?????_010_0010011: w_ctrl = MI_SLTI;
      22'b???????_?????_011_0010011: w_ctrl = MI_SLTIU;
      22'b???????_?????_100_0010011: w_ctrl = MI_XORI;
      22'b???????_?????_110_0010011: w_ctrl = MI_ORI;
      22'b???????_?????_111_0010011: w_ctrl = MI_ANDI;
      22'b0000000_?????_001_0010011: w_ctrl = MI_SLLI;
      22'b0000000_?????_101_0010011: w_ctrl = MI_SRLI;
      22'b0100000_?????_101_0010011: w_ctrl = MI_SRAI;
      22'b0000000_?????_000_0110011: w_ctrl = MI_ADD;
      22'b0100000_?????_000_0110011: w_ctrl = MI_SUB;
      22'b0000000_?????_001_0110011: w_ctrl = MI_SLL;
      22'b0000000_?????_010_0110011: w_ctrl = MI_SLT;
      22'b0000000_?????_011_0110011: w_ctrl = MI_SLTU;
      22'b0000000_?????_100_0110011: w_ctrl = MI_XOR;
      22'b0000000_?????_101_0110011: w_ctrl = MI_SRL;
      22'b0100000_?????_101_0110011: w_ctrl = MI_SRA;
      22'b0000000_?????_110_0110011: w_ctrl = MI_OR;
      22'b0000000_?????_111_0110011: w_ctrl = MI_AND;
`ifdef ZBB_CNT_EN
      22'b0110000_00000_001_0010011: w_ctrl = MI_CLZ;
      22'b0110000_00001_001_0010011: w_ctrl = MI_CTZ;
      22'b0110000_00010_001_0010011: w_ctrl = MI_CPOP;
`endif
      default: begin
        w_ctrl    = MI_ADDI;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign ready_o  = !r_skid_valid;
  assign w_accept = valid_i & ready_o;
  assign w_emit   = r_head_valid & ready_i;

  // Skid only fills while the head is held, so it never coexists with an accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head_valid <= 1'b0;
      r_head_instr <= '0;
      r_head_pc    <= '0;
      r_head_ctrl  <= '0;
      r_head_ill   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_ctrl  <= '0;
      r_skid_ill   <= 1'b0;
    end else if (flush_i) begin
      r_head_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_head_valid || w_emit) begin
      if (r_skid_valid) begin
        r_head_valid <= 1'b1;
        r_head_instr <= r_skid_instr;
        r_head_pc    <= r_skid_pc;
        r_head_ctrl  <= r_skid_ctrl;
        r_head_ill   <= r_skid_ill;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_head_valid <= 1'b1;
        r_head_instr <= instr_i;
        r_head_pc    <= pc_i;
        r_head_ctrl  <= CTRL_W'(w_ctrl);
        r_head_ill   <= w_illegal;
      end else begin
        r_head_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= instr_i;
      r_skid_pc    <= pc_i;
      r_skid_ctrl  <= CTRL_W'(w_ctrl);
      r_skid_ill   <= w_illegal;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_accept && w_illegal && !flush_i && r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign valid_o       = r_head_valid;
  assign instr_o       = r_head_instr;
  assign pc_o          = r_head_pc;
  assign ctrl_o        = r_head_ctrl;
  assign illegal_o     = r_head_ill;
  assign illegal_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module : tb_decode_stage
//  Directed self-checking bench for decode_stage (default and CNT_W=2 builds).
//  Rev    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

  localparam logic [17:0] MI_ADDI = 18'h20820;
  localparam logic [17:0] MI_SUB  = 18'h20001;
  localparam logic [17:0] MI_ADD  = 18'h20000;
  localparam logic [17:0] MI_LOAD = 18'h30920;
  localparam logic [17:0] MI_CTZ  = 18'h20011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;

  logic        ready_out, valid_out, ill_out;
  logic [31:0] instr_out, pc_out;
  logic [17:0] ctrl_out;
  logic [15:0] cnt_out;

  logic        s_ready, s_valid, s_ill;
  logic [31:0] s_instr, s_pc;
  logic [17:0] s_ctrl;
  logic [1:0]  s_cnt;

  int checks = 0;
  int passes = 0;
  int exp_cnt = 0;

  decode_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in),
    .ready_o(ready_out), .instr_i(instr_in), .pc_i(pc_in),
    .valid_o(valid_out), .ready_i(ready_in), .instr_o(instr_out),
    .pc_o(pc_out), .ctrl_o(ctrl_out), .illegal_o(ill_out),
    .illegal_cnt_o(cnt_out)
  );

  decode_stage #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in),
    .ready_o(s_ready), .instr_i(instr_in), .pc_i(pc_in),
    .valid_o(s_valid), .ready_i(ready_in), .instr_o(s_instr),
    .pc_o(s_pc), .ctrl_o(s_ctrl), .illegal_o(s_ill),
    .illegal_cnt_o(s_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    valid_in = v;
    instr_in = ins;
    pc_in    = pc;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1 || ill_out !== 1'b0) begin
      $display("FAIL reset_flags: valid=%b ready=%b ill=%b required 0 1 0", valid_out, ready_out, ill_out);
    end else passes++;
    checks++;
    if (instr_out !== 32'h0 || pc_out !== 32'h0 || ctrl_out !== 18'h0 || cnt_out !== 16'h0) begin
      $display("FAIL reset_payload: instr=%h pc=%h ctrl=%h cnt=%0d required zeros", instr_out, pc_out, ctrl_out, cnt_out);
    end else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addi;
    ready_in = 1'b1;
    drive(1'b1, 32'h00500093, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (valid_out !== 1'b1 || ctrl_out !== MI_ADDI || pc_out !== 32'h100 || ill_out !== 1'b0 || instr_out !== 32'h00500093) begin
      $display("FAIL addi: valid=%b ctrl=%h pc=%h ill=%b instr=%h required 1 %h 100 0 00500093", valid_out, ctrl_out, pc_out, ill_out, instr_out, MI_ADDI);
    end else passes++;
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      $display("FAIL addi_drain: valid=%b required 0", valid_out);
    end else passes++;
  endtask

  task automatic test_decode_table;
    logic [31:0] ins [3] = '{32'h002081B3, 32'h0000A103, 32'h40208033};
    logic [17:0] exp [3] = '{MI_ADD, MI_LOAD, MI_SUB};
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ins[i], 32'h180 + 32'(i * 4));
      tick();
      checks++;
      if (valid_out !== 1'b1 || ctrl_out !== exp[i] || ill_out !== 1'b0 || pc_out !== 32'h180 + 32'(i * 4)) begin
        $display("FAIL decode_%0d: valid=%b ctrl=%h ill=%b pc=%h required 1 %h 0 %h", i, valid_out, ctrl_out, ill_out, pc_out, exp[i], 32'h180 + 32'(i * 4));
      end else passes++;
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_illegal;
    ready_in = 1'b1;
    drive(1'b1, 32'h00000000, 32'h104);
    tick();
    exp_cnt++;
    drive(1'b1, 32'hFFFFFFFF, 32'h108);
    checks++;
    if (valid_out !== 1'b1 || ill_out !== 1'b1 || ctrl_out !== MI_ADDI || instr_out !== 32'h0) begin
      $display("FAIL illegal_zero: valid=%b ill=%b ctrl=%h instr=%h required 1 1 %h 0", valid_out, ill_out, ctrl_out, instr_out, MI_ADDI);
    end else passes++;
    tick();
    exp_cnt++;
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (valid_out !== 1'b1 || ill_out !== 1'b1 || instr_out !== 32'hFFFFFFFF || pc_out !== 32'h108) begin
      $display("FAIL illegal_ones: valid=%b ill=%b instr=%h pc=%h required 1 1 ffffffff 108", valid_out, ill_out, instr_out, pc_out);
    end else passes++;
    checks++;
    if (cnt_out !== 16'(exp_cnt)) begin
      $display("FAIL illegal_cnt: got %0d required %0d", cnt_out, exp_cnt);
    end else passes++;
    tick();
  endtask

  task automatic test_back_to_back;
    ready_in = 1'b0;
    drive(1'b1, 32'h00500093, 32'h200);
    tick();
    drive(1'b1, 32'h40208033, 32'h204);
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b1) begin
      $display("FAIL b2b_first: ready=%b valid=%b required 1 1", ready_out, valid_out);
    end else passes++;
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (ready_out !== 1'b0 || ctrl_out !== MI_ADDI || pc_out !== 32'h200) begin
      $display("FAIL b2b_full: ready=%b ctrl=%h pc=%h required 0 %h 200", ready_out, ctrl_out, pc_out, MI_ADDI);
    end else passes++;
    tick();
    checks++;
    if (ready_out !== 1'b0 || valid_out !== 1'b1 || ctrl_out !== MI_ADDI || pc_out !== 32'h200) begin
      $display("FAIL b2b_hold: ready=%b valid=%b ctrl=%h pc=%h required 0 1 %h 200", ready_out, valid_out, ctrl_out, pc_out, MI_ADDI);
    end else passes++;
    ready_in = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b1 || ctrl_out !== MI_SUB || pc_out !== 32'h204 || ready_out !== 1'b1) begin
      $display("FAIL b2b_second: valid=%b ctrl=%h pc=%h ready=%b required 1 %h 204 1", valid_out, ctrl_out, pc_out, ready_out, MI_SUB);
    end else passes++;
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      $display("FAIL b2b_drain: valid=%b required 0", valid_out);
    end else passes++;
  endtask

  task automatic test_flush;
    ready_in = 1'b0;
    drive(1'b1, 32'h00500093, 32'h300);
    tick();
    drive(1'b1, 32'h40208033, 32'h304);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h00000000, 32'h308);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1 || cnt_out !== 16'(exp_cnt)) begin
      $display("FAIL flush_full: valid=%b ready=%b cnt=%0d required 0 1 %0d", valid_out, ready_out, cnt_out, exp_cnt);
    end else passes++;
    ready_in = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      $display("FAIL flush_no_emit: valid=%b required 0", valid_out);
    end else passes++;
    // Flush with an accepted illegal beat: dropped and not counted.
    ready_in = 1'b0;
    drive(1'b1, 32'h00500093, 32'h310);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h00000000, 32'h314);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    ready_in = 1'b1;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1 || cnt_out !== 16'(exp_cnt)) begin
      $display("FAIL flush_accept: valid=%b ready=%b cnt=%0d required 0 1 %0d", valid_out, ready_out, cnt_out, exp_cnt);
    end else passes++;
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      $display("FAIL flush_dropped: valid=%b required 0", valid_out);
    end else passes++;
  endtask

  task automatic test_zbb;
    logic [17:0] exp_ctrl;
    logic        exp_ill;
`ifdef ZBB_CNT_EN
    exp_ctrl = MI_CTZ;
    exp_ill  = 1'b0;
`else
    exp_ctrl = MI_ADDI;
    exp_ill  = 1'b1;
    exp_cnt++;
`endif
    ready_in = 1'b1;
    drive(1'b1, 32'h60111093, 32'h400);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (valid_out !== 1'b1 || ctrl_out !== exp_ctrl || ill_out !== exp_ill) begin
      $display("FAIL zbb_ctz: valid=%b ctrl=%h ill=%b required 1 %h %b", valid_out, ctrl_out, ill_out, exp_ctrl, exp_ill);
    end else passes++;
    checks++;
    if (cnt_out !== 16'(exp_cnt)) begin
      $display("FAIL zbb_cnt: got %0d required %0d", cnt_out, exp_cnt);
    end else passes++;
    tick();
  endtask

  task automatic test_saturate;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h00000000, 32'h500 + 32'(i * 4));
      tick();
      exp_cnt++;
    end
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (s_cnt !== 2'd3) begin
      $display("FAIL sat_cnt: got %0d required 3", s_cnt);
    end else passes++;
    checks++;
    if (cnt_out !== 16'(exp_cnt)) begin
      $display("FAIL wide_cnt: got %0d required %0d", cnt_out, exp_cnt);
    end else passes++;
    // Leave a beat held in the head, then reset asynchronously between edges.
    ready_in = 1'b0;
    drive(1'b1, 32'h00500093, 32'h600);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || cnt_out !== 16'h0 || s_cnt !== 2'd0 || s_valid !== 1'b0 || ready_out !== 1'b1) begin
      $display("FAIL async_rst: valid=%b cnt=%0d s_cnt=%0d s_valid=%b ready=%b required 0 0 0 0 1", valid_out, cnt_out, s_cnt, s_valid, ready_out);
    end else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_decode_table();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_zbb();
    test_saturate();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
